// File: rtl/ibex_pkg.sv
// Shared types for the ID-stage side of the slow multiply/divide interface.
package ibex_pkg;

    typedef enum logic [1:0] {
        MD_OP_MULL,
        MD_OP_MULH,
        MD_OP_DIV,
        MD_OP_REM
    } md_op_e;

    typedef enum logic [1:0] {
        MD_ISSUE_IDLE,
        MD_ISSUE_BUSY,
        MD_ISSUE_DONE,
        MD_ISSUE_DRAIN
    } md_issue_e;

    localparam int unsigned IMD_W = 34;

endpackage

// File: rtl/ibex_multdiv_adder.sv
// Shared 33+33 -> 34-bit unsigned adder used by the iterative mult/div datapath.
module ibex_multdiv_adder
    import ibex_pkg::*;
(
    input  logic [32:0]      operand_a_i,
    input  logic [32:0]      operand_b_i,
    output logic [IMD_W-1:0] adder_ext_o,
    output logic [31:0]      adder_o,
    output logic             equal_to_zero_o
);

    // Zero-extend both operands so the carry lands in bit 33 rather than being lost.
    assign adder_ext_o     = {1'b0, operand_a_i} + {1'b0, operand_b_i};
    assign adder_o         = adder_ext_o[32:1];
    assign equal_to_zero_o = (adder_o == 32'd0);

endmodule

// File: rtl/ibex_multdiv_issue.sv
// Issue/handshake FSM between ID and the slow mult/div unit: latches the request,
// keeps the unit enabled until it reports valid, owns imd_val and returns the result.
module ibex_multdiv_issue
    import ibex_pkg::*;
#(
    parameter logic ResultReg = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    input  logic              req_is_div_i,
    input  md_op_e            req_op_i,
    input  logic [1:0]        req_signed_mode_i,
    input  logic [31:0]       req_rs1_i,
    input  logic [31:0]       req_rs2_i,
    output logic              req_ready_o,
    input  logic              kill_i,
    input  logic              wb_ready_i,
    output logic              result_valid_o,
    output logic [31:0]       result_o,
    output logic              mult_en_o,
    output logic              div_en_o,
    output md_op_e            operator_o,
    output logic [1:0]        signed_mode_o,
    output logic [31:0]       op_a_o,
    output logic [31:0]       op_b_o,
    input  logic [32:0]       alu_operand_a_i,
    input  logic [32:0]       alu_operand_b_i,
    output logic [IMD_W-1:0]  alu_adder_ext_o,
    output logic [31:0]       alu_adder_o,
    output logic              equal_to_zero_o,
    input  logic [IMD_W-1:0]  imd_val_d_i,
    input  logic              imd_val_we_i,
    output logic [IMD_W-1:0]  imd_val_q_o,
    output logic              multdiv_ready_id_o,
    input  logic [31:0]       multdiv_result_i,
    input  logic              valid_i
);

    md_issue_e        state_q, state_d;
    md_op_e           op_q, op_d;
    logic [1:0]       mode_q, mode_d;
    logic [31:0]      rs1_q, rs1_d;
    logic [31:0]      rs2_q, rs2_d;
    logic             is_div_q, is_div_d;
    logic [31:0]      result_q, result_d;
    logic [IMD_W-1:0] imd_val_q, imd_val_d;

    logic enabled;
    logic accept;

    ibex_multdiv_adder u_adder (
        .operand_a_i     (alu_operand_a_i),
        .operand_b_i     (alu_operand_b_i),
        .adder_ext_o     (alu_adder_ext_o),
        .adder_o         (alu_adder_o),
        .equal_to_zero_o (equal_to_zero_o)
    );

    // The unit freezes when disabled, so enables stay up through BUSY and DRAIN alike.
    assign enabled = ((state_q == MD_ISSUE_BUSY) || (state_q == MD_ISSUE_DRAIN)) && !rst_i;
    assign accept  = (state_q == MD_ISSUE_IDLE) && req_valid_i && !kill_i && !rst_i;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        op_d      = op_q;
        mode_d    = mode_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        is_div_d  = is_div_q;
        result_d  = result_q;
        imd_val_d = (imd_val_we_i && enabled) ? imd_val_d_i : imd_val_q;

        unique case (state_q)
            MD_ISSUE_IDLE: begin
                if (accept) begin
                    op_d     = req_op_i;
                    mode_d   = req_signed_mode_i;
                    rs1_d    = req_rs1_i;
                    rs2_d    = req_rs2_i;
                    is_div_d = req_is_div_i;
                    state_d  = MD_ISSUE_BUSY;
                end
            end
            MD_ISSUE_BUSY: begin
                if (kill_i) begin
                    state_d = valid_i ? MD_ISSUE_IDLE : MD_ISSUE_DRAIN;
                end else if (ResultReg) begin
                    if (valid_i) begin
                        result_d = multdiv_result_i;
                        state_d  = MD_ISSUE_DONE;
                    end
                end else if (valid_i && wb_ready_i) begin
                    state_d = MD_ISSUE_IDLE;
                end
            end
            MD_ISSUE_DONE: begin
                if (kill_i || wb_ready_i) state_d = MD_ISSUE_IDLE;
            end
            MD_ISSUE_DRAIN: begin
                if (valid_i) state_d = MD_ISSUE_IDLE;
            end
            default: state_d = MD_ISSUE_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o        = accept;
        mult_en_o          = enabled && !is_div_q;
        div_en_o           = enabled && is_div_q;
        multdiv_ready_id_o = 1'b0;
        result_valid_o     = 1'b0;
        if (!rst_i) begin
            unique case (state_q)
                MD_ISSUE_BUSY: begin
                    multdiv_ready_id_o = ResultReg ? 1'b1 : wb_ready_i;
                    result_valid_o     = !ResultReg && valid_i && !kill_i;
                end
                MD_ISSUE_DONE:  result_valid_o     = !kill_i;
                MD_ISSUE_DRAIN: multdiv_ready_id_o = 1'b1;
                default: ;
            endcase
        end
    end

    assign result_o      = ResultReg ? result_q : (result_valid_o ? multdiv_result_i : 32'd0);
    assign operator_o    = op_q;
    assign signed_mode_o = mode_q;
    assign op_a_o        = rs1_q;
    assign op_b_o        = rs2_q;
    assign imd_val_q_o   = imd_val_q;

    always_ff @(posedge clk_i) begin
        // NOTE: state is updated with non-blocking assignments so all flops sample the same pre-edge values.
        if (rst_i) begin
            state_q   <= MD_ISSUE_IDLE;
            op_q      <= MD_OP_MULL;
            mode_q    <= 2'b00;
            rs1_q     <= 32'd0;
            rs2_q     <= 32'd0;
            is_div_q  <= 1'b0;
            result_q  <= 32'd0;
            imd_val_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            mode_q    <= mode_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            is_div_q  <= is_div_d;
            result_q  <= result_d;
            imd_val_q <= imd_val_d;
        end
    end

endmodule
